pipe_stage_reg: RTL and testbench

- Generic parametrised pipeline stage register, successor to the fixed per-signal stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload between pipeline stages using valid/ready handshaking.
- Adds stall back-pressure, flush-to-bubble, an optional skid buffer and per-stage stall/bubble performance counters.
- One instance per stage boundary; the hazard unit drives flush, and the downstream stage drives out_ready.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 192,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              in_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;

    generate
        if (SKID != 0) begin : g_skid
            logic              s_valid;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;

            // in_ready comes straight from a flop: no out_ready -> in_ready path.
            assign in_ready = ~s_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                end else if (!m_valid || out_ready) begin
                    if (s_valid) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_valid <= in_fire;
                        if (in_fire) begin
                            s_ctrl <= in_ctrl;
                            s_data <= in_data;
                        end
                    end else if (in_fire) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end else if (in_fire) begin
                    s_valid <= 1'b1;
                    s_ctrl  <= in_ctrl;
                    s_data  <= in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready = out_ready | ~m_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (out_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!m_valid && out_ready && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-register instance,
// each checked every cycle against a queue-based occupancy model.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned DATA_W = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid  [2];
    logic              in_ready  [2];
    logic              out_valid [2];
    logic              out_ready [2];
    logic              flush     [2];
    logic              clr_cnt   [2];
    logic [CTRL_W-1:0] in_ctrl   [2];
    logic [CTRL_W-1:0] out_ctrl  [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [DATA_W-1:0] out_data  [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned SK  = (g == 0) ? 1 : 0;
        localparam int unsigned CW  = (g == 0) ? 8 : 4;
        localparam int unsigned CAP = (g == 0) ? 2 : 1;
        localparam int          SAT = (1 << CW) - 1;

        logic [CW-1:0] stall_cnt, bubble_cnt;

        pipe_stage_reg #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W),
            .SKID   (SK),
            .CNT_W  (CW)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_ctrl    (in_ctrl[g]),
            .in_data    (in_data[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_ctrl   (out_ctrl[g]),
            .out_data   (out_data[g]),
            .flush      (flush[g]),
            .clr_cnt    (clr_cnt[g]),
            .stall_cnt  (stall_cnt),
            .bubble_cnt (bubble_cnt)
        );

        // Entries accepted but not yet delivered, oldest first.
        logic [CTRL_W-1:0] qc[$];
        logic [DATA_W-1:0] qd[$];
        int ms = 0;
        int mb = 0;

        always @(negedge clk) begin
            bit ev, er, ofire, ifire;
            if (!rst) begin
                qc.delete();
                qd.delete();
                ms = 0;
                mb = 0;
                check($sformatf("%0d.rst_valid", g), 64'(out_valid[g]), 64'd0);
                check($sformatf("%0d.rst_ctrl", g), 64'(out_ctrl[g]), 64'd0);
                check($sformatf("%0d.rst_ready", g), 64'(in_ready[g]), 64'd1);
                check($sformatf("%0d.rst_stall", g), 64'(stall_cnt), 64'd0);
                check($sformatf("%0d.rst_bubble", g), 64'(bubble_cnt), 64'd0);
            end else begin
                ev = (qc.size() > 0);
                er = (CAP == 2) ? (qc.size() < 2) : (out_ready[g] || qc.size() == 0);
                check($sformatf("%0d.valid", g), 64'(out_valid[g]), 64'(ev));
                check($sformatf("%0d.ready", g), 64'(in_ready[g]), 64'(er));
                check($sformatf("%0d.ctrl", g), 64'(out_ctrl[g]), ev ? 64'(qc[0]) : 64'd0);
                if (ev)
                    check($sformatf("%0d.data", g), 64'(out_data[g]), 64'(qd[0]));
                check($sformatf("%0d.stall", g), 64'(stall_cnt), 64'(ms));
                check($sformatf("%0d.bubble", g), 64'(bubble_cnt), 64'(mb));

                ofire = ev && out_ready[g];
                ifire = in_valid[g] && er;
                if (clr_cnt[g]) begin
                    ms = 0;
                    mb = 0;
                end else begin
                    if (ev && !out_ready[g] && ms < SAT) ms++;
                    if (!ev && out_ready[g] && mb < SAT) mb++;
                end
                if (flush[g]) begin
                    qc.delete();
                    qd.delete();
                end else begin
                    if (ofire) begin
                        void'(qc.pop_front());
                        void'(qd.pop_front());
                    end
                    if (ifire) begin
                        qc.push_back(in_ctrl[g]);
                        qd.push_back(in_data[g]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input bit v, input logic [CTRL_W-1:0] c, input bit ordy,
                             input bit fl, input bit clr);
        logic [63:0] d;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            in_valid[i]  = v;
            in_ctrl[i]   = c;
            in_data[i]   = d[DATA_W-1:0];
            out_ready[i] = ordy;
            flush[i]     = fl;
            clr_cnt[i]   = clr;
        end
    endtask

    initial begin
        logic [63:0] d;
        rst = 1'b0;
        drive_all(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();

        // Streaming ctrl 1..4 with no back-pressure.
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step();
        for (int c = 1; c <= 4; c++) begin
            drive_all(1'b1, CTRL_W'(c), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        // Stall: A, B then C held upstream, then release.
        drive_all(1'b1, 16'h00A0, 1'b0, 1'b0, 1'b0);
        step();
        drive_all(1'b1, 16'h00B0, 1'b0, 1'b0, 1'b0);
        step();
        drive_all(1'b1, 16'h00C0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        drive_all(1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0);
        repeat (2) step();
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        // Flush while stalled with C offered alongside.
        drive_all(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
        step();
        drive_all(1'b1, 16'h00B1, 1'b0, 1'b0, 1'b0);
        step();
        drive_all(1'b1, 16'h00C1, 1'b0, 1'b1, 1'b0);
        step();
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (2) step();

        // Idle long enough for the 4-bit bubble counter to saturate, then clear.
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (20) step();
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step();
        drive_all(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (2) step();

        // Random traffic including flushes, counter clears and rare resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                d = {$urandom, $urandom};
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                in_ctrl[i]   = CTRL_W'($urandom);
                in_data[i]   = d[DATA_W-1:0];
                out_ready[i] = ($urandom_range(0, 9) < 6);
                flush[i]     = ($urandom_range(0, 24) == 0);
                clr_cnt[i]   = ($urandom_range(0, 199) == 0);
            end
            rst = ($urandom_range(0, 699) != 0);
            step();
        end
        rst = 1'b1;
        drive_all(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
